enable_counter: RTL and testbench

Parameterised synchronous up/down counter with count enable, synchronous clear, terminal-count flag and optional parallel load. It is a general-purpose event/cycle counter for control-path blocks: the count advances by one on each enabled clock edge and wraps at the configured limit. With default parameters it is a 4-bit free-wrapping up counter gated by `enable`.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_tc_detect.sv | 25 ++
 rtl/enable_counter.sv | 68 ++++++
 tb/tb_enable_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } count_dir_e;

    // Next value of a counter that wraps between 0 and max in either direction.
    function automatic logic [31:0] next_count(
        input logic [31:0] count,
        input count_dir_e  dir,
        input logic [31:0] max
    );
        logic [31:0] nxt;
        if (dir == UP) begin
            nxt = (count == max) ? '0 : count + 32'd1;
        end else begin
            nxt = (count == '0) ? max : count - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// Terminal-count comparator: flags the count value at which the next step wraps.
module counter_tc_detect
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH     = COUNTER_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     MAX_VALUE = '1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             down,
    output logic             tc,
    output logic             wrap_cond
);

    logic at_max;
    logic at_zero;

    // Terminal value depends on direction; a step taken from it wraps.
    always_comb begin
        at_max    = (count == MAX_VALUE);
        at_zero   = (count == '0);
        tc        = down ? at_zero : at_max;
        wrap_cond = tc;
    end

endmodule

// File: rtl/enable_counter.sv
// Up/down counter with enable, synchronous clear, terminal count and wrap pulse.
// Optional parallel load compiled in with COUNTER_LOAD_EN.
module enable_counter
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH     = COUNTER_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     MAX_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             down,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    count_dir_e       dir;
    logic             wrap_cond;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    counter_tc_detect #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_tc_detect (
        .count     (count),
        .down      (down),
        .tc        (tc),
        .wrap_cond (wrap_cond)
    );

    // Priority: clear, then load (if present), then enabled step, else hold.
    always_comb begin
        dir       = down ? DOWN : UP;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end
`ifdef COUNTER_LOAD_EN
        else if (load) begin
            count_nxt = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
        end
`endif
        else if (enable) begin
            count_nxt = WIDTH'(next_count(32'(count), dir, 32'(MAX_VALUE)));
            wrap_nxt  = wrap_cond;
        end
    end

    // Count and wrap-pulse registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_enable_counter.sv
// Scoreboard bench for enable_counter: a default instance (4-bit, max 15)
// and a modulo-10 instance (max 9) share stimulus. Load ports with COUNTER_LOAD_EN.
module tb_enable_counter;

`ifdef COUNTER_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       down;
    logic       load;
    logic [3:0] load_value;

    logic [3:0] count0, count9;
    logic       tc0, tc9, wrap0, wrap9;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c0;
        bit w0;
        bit t0;
        int c1;
        bit w1;
        bit t1;
    } exp_t;

    exp_t q[$];

    // Reference model state: index 0 = max 15, index 1 = max 9
    int m_c[2];
    bit m_w[2];
    bit m_t[2];
    int maxv[2] = '{15, 9};

    always #5 clk = ~clk;

    enable_counter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .down       (down),
`ifdef COUNTER_LOAD_EN
        .load       (load),
        .load_value (load_value),
`endif
        .count      (count0),
        .tc         (tc0),
        .wrap       (wrap0)
    );

    enable_counter #(
        .WIDTH     (4),
        .MAX_VALUE (4'd9)
    ) dut9 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .down       (down),
`ifdef COUNTER_LOAD_EN
        .load       (load),
        .load_value (load_value),
`endif
        .count      (count9),
        .tc         (tc9),
        .wrap       (wrap9)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp();
        exp_t e;
        e.c0 = m_c[0]; e.w0 = m_w[0]; e.t0 = m_t[0];
        e.c1 = m_c[1]; e.w1 = m_w[1]; e.t1 = m_t[1];
        q.push_back(e);
    endfunction

    // Model of one clock edge from the priority rules, using modular arithmetic.
    function automatic void model_edge(input bit en, input bit clr, input bit dn,
                                       input bit ld, input int lv);
        for (int i = 0; i < 2; i++) begin
            m_w[i] = 1'b0;
            if (clr) begin
                m_c[i] = 0;
            end else if (LOAD_EN && ld) begin
                m_c[i] = (lv > maxv[i]) ? maxv[i] : lv;
            end else if (en) begin
                if (!dn) begin
                    m_w[i] = (m_c[i] == maxv[i]);
                    m_c[i] = (m_c[i] + 1) % (maxv[i] + 1);
                end else begin
                    m_w[i] = (m_c[i] == 0);
                    m_c[i] = (m_c[i] + maxv[i]) % (maxv[i] + 1);
                end
            end
            m_t[i] = dn ? (m_c[i] == 0) : (m_c[i] == maxv[i]);
        end
    endfunction

    task automatic step(input bit en, input bit clr, input bit dn, input bit ld, input int lv);
        @(posedge clk);
        #2;
        reset      = 1'b1;
        enable     = en;
        clear      = clr;
        down       = dn;
        load       = ld;
        load_value = 4'(lv);
        model_edge(en, clr, dn, ld, lv);
        push_exp();
    endtask

    // Assert reset between edges; count must drop without a clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_c[i] = 0;
            m_w[i] = 1'b0;
            m_t[i] = down ? 1'b1 : 1'b0;
        end
        push_exp();
        #1;
        chk("async_reset_count0", 32'(count0), 0);
        chk("async_reset_count9", 32'(count9), 0);
        chk("async_reset_wrap0", 32'(wrap0), 0);
    endtask

    // Monitor: compares every registered output sample against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_max15", 32'(count0), 32'(e.c0));
                chk("wrap_max15",  32'(wrap0),  32'(e.w0));
                chk("tc_max15",    32'(tc0),    32'(e.t0));
                chk("count_max9",  32'(count9), 32'(e.c1));
                chk("wrap_max9",   32'(wrap9),  32'(e.w1));
                chk("tc_max9",     32'(tc9),    32'(e.t1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        down       = 1'b0;
        load       = 1'b0;
        load_value = '0;
        m_c = '{0, 0};
        m_w = '{1'b0, 1'b0};
        m_t = '{1'b0, 1'b0};
        #3;
        chk("reset_count", 32'(count0), 0);
        chk("reset_wrap", 32'(wrap0), 0);
        chk("reset_tc", 32'(tc0), 0);
        // Cycle still in reset: outputs stay zero
        @(posedge clk);
        #2;
        push_exp();

        // Count 1..5 after release
        repeat (5) step(1, 0, 0, 0, 0);
        // Hold at 5
        repeat (5) step(0, 0, 0, 0, 0);
        // Up to 14, then 15 (tc) and wrap to 0
        repeat (9) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Down from 1: 0 (tc), then wrap to max
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Up to 7 then clear with enable
        repeat (8) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // Up to 3 then reset mid-cycle
        repeat (3) step(1, 0, 0, 0, 0);
        reset_mid();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        // Load clamp, load vs enable, clear vs load
        step(0, 0, 0, 1, 12);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 4);
        step(1, 1, 0, 1, 6);
        step(0, 0, 1, 1, 15);
        step(1, 0, 1, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset_mid();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 15)));
            end
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
